// File: rtl/sysblock_acc.sv
// Systolic MAC cell: forwards operands east/south, accumulates ACC_LEN fp32 products and
// hands each finished result to a drain chain that gives priority to the neighbour above.
module sysblock_acc #(
    parameter int unsigned ACC_LEN = 4,
    parameter int unsigned PIPE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] up,
    input  logic [31:0] left,
    input  logic        up_valid,
    input  logic        left_valid,
    input  logic        clear,
    input  logic [31:0] res_in,
    input  logic        res_in_valid,
    output logic [31:0] down,
    output logic [31:0] right,
    output logic        down_valid,
    output logic        right_valid,
    output logic [31:0] res_out,
    output logic        res_out_valid,
    output logic        ovf
);

    localparam int unsigned CW = $clog2(ACC_LEN + 1);

    // Denormals flush to zero; rounding is nearest-even.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       p;
        logic [22:0]       m;
        logic              g, s, sign;
        logic signed [9:0] e;
        logic [24:0]       rnd;
        sign = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sign, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m = p[46:24];
            g = p[23];
            s = |p[22:0];
            e = e + 10'sd1;
        end else begin
            m = p[45:23];
            g = p[22];
            s = |p[21:0];
        end
        rnd = {2'b01, m} + {24'd0, g & (s | m[0])};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'sd1;
        end
        if (e >= 10'sd255) return {sign, 8'hff, 23'd0};
        if (e <= 10'sd0) return {sign, 31'd0};
        return {sign, e[7:0], rnd[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y;
        logic [26:0]       mx, my, mask;
        logic [27:0]       sum;
        logic [7:0]        d;
        logic signed [9:0] e;
        logic [24:0]       rnd;
        logic              rb;
        if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? 32'd0 : b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        // Three guard bits below the mantissa; bit 0 doubles as sticky.
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        d  = x[30:23] - y[30:23];
        if (d > 8'd26) begin
            my = 27'd1;
        end else begin
            mask = (27'd1 << d) - 27'd1;
            my   = (my >> d) | {26'd0, |(my & mask)};
        end
        e = $signed({2'b00, x[30:23]});
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, my};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 10'sd1;
            end
        end else begin
            sum = {1'b0, mx} - {1'b0, my};
            if (sum == 28'd0) return 32'd0;
            for (int i = 0; i < 26; i++) begin
                if (!sum[26]) begin
                    sum = sum << 1;
                    e   = e - 10'sd1;
                end
            end
        end
        rb  = sum[2] & (sum[1] | sum[0] | sum[3]);
        rnd = {1'b0, sum[26:3]} + {24'd0, rb};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'sd1;
        end
        if (e >= 10'sd255) return {x[31], 8'hff, 23'd0};
        if (e <= 10'sd0) return {x[31], 31'd0};
        return {x[31], e[7:0], rnd[22:0]};
    endfunction

    logic          fire, acc_en, last, send;
    logic [31:0]   prod_now, acc_prod, sum;
    logic [31:0]   prod_q, acc_q, pend_data_q;
    logic          prod_valid_q, pend_valid_q;
    logic [CW-1:0] count_q;

    assign fire     = up_valid & left_valid & ~clear;
    assign prod_now = fp_mul(up, left);

    // clear also kills a registered product that has not been accumulated yet.
    always_comb begin
        if (PIPE != 0) begin
            acc_en   = prod_valid_q & ~clear;
            acc_prod = prod_q;
        end else begin
            acc_en   = fire;
            acc_prod = prod_now;
        end
    end

    assign sum  = fp_add(acc_q, acc_prod);
    assign last = acc_en & (count_q == CW'(ACC_LEN - 1));
    assign send = pend_valid_q & ~res_in_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            down        <= 32'd0;
            right       <= 32'd0;
            down_valid  <= 1'b0;
            right_valid <= 1'b0;
        end else begin
            down        <= up;
            right       <= left;
            down_valid  <= up_valid;
            right_valid <= left_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q       <= 32'd0;
            prod_valid_q <= 1'b0;
        end else begin
            prod_valid_q <= fire;
            if (fire) prod_q <= prod_now;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= 32'd0;
            count_q <= '0;
        end else if (clear || last) begin
            acc_q   <= 32'd0;
            count_q <= '0;
        end else if (acc_en) begin
            acc_q   <= sum;
            count_q <= count_q + CW'(1);
        end
    end

    // A new load always wins the pending slot; an unsent older value is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_data_q  <= 32'd0;
            pend_valid_q <= 1'b0;
            ovf          <= 1'b0;
        end else if (clear) begin
            pend_valid_q <= 1'b0;
            ovf          <= 1'b0;
        end else if (last) begin
            pend_data_q  <= sum;
            pend_valid_q <= 1'b1;
            if (pend_valid_q && !send) ovf <= 1'b1;
        end else if (send) begin
            pend_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_out       <= 32'd0;
            res_out_valid <= 1'b0;
        end else if (res_in_valid) begin
            res_out       <= res_in;
            res_out_valid <= 1'b1;
        end else if (pend_valid_q) begin
            res_out       <= pend_data_q;
            res_out_valid <= 1'b1;
        end else begin
            res_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sysblock_acc.sv
// Scoreboard bench for sysblock_acc (ACC_LEN=4, PIPE=1); operands are small integers so
// every expected fp32 result is exact and derived from integer arithmetic.
module tb_sysblock_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] up = 32'd0, left = 32'd0, res_in = 32'd0;
    logic        up_valid = 1'b0, left_valid = 1'b0, clear = 1'b0, res_in_valid = 1'b0;
    logic [31:0] down, right, res_out;
    logic        down_valid, right_valid, res_out_valid, ovf;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    sysblock_acc #(.ACC_LEN(4), .PIPE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .up           (up),
        .left         (left),
        .up_valid     (up_valid),
        .left_valid   (left_valid),
        .clear        (clear),
        .res_in       (res_in),
        .res_in_valid (res_in_valid),
        .down         (down),
        .right        (right),
        .down_valid   (down_valid),
        .right_valid  (right_valid),
        .res_out      (res_out),
        .res_out_valid(res_out_valid),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] int_to_fp(input int unsigned v);
        int          msb;
        logic [31:0] frac;
        if (v == 0) return 32'd0;
        msb = 0;
        for (int i = 0; i < 32; i++) if (v[i]) msb = i;
        frac = v << (23 - msb);
        return {1'b0, 8'(127 + msb), frac[22:0]};
    endfunction

    always @(negedge clk) begin
        if (rst && res_out_valid) begin
            if (exp_q.size() == 0) check("spurious_res_out", {31'd0, res_out_valid}, 32'd0);
            else check("res_out", res_out, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        up_valid     = 1'b0;
        left_valid   = 1'b0;
        clear        = 1'b0;
        res_in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic fire(input int unsigned a, input int unsigned b);
        up         = int_to_fp(a);
        left       = int_to_fp(b);
        up_valid   = 1'b1;
        left_valid = 1'b1;
        step();
    endtask

    task automatic mac_group(input bit rand_ops, input int unsigned a0, input int unsigned b0,
                             input bit push);
        int unsigned s, a, b;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            a = rand_ops ? $urandom_range(0, 7) : a0;
            b = rand_ops ? $urandom_range(0, 7) : b0;
            s += a * b;
            if (i == 3 && push) exp_q.push_back(int_to_fp(s));
            fire(a, b);
        end
        up_valid   = 1'b0;
        left_valid = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        check("rst_down", down, 32'd0);
        check("rst_right", right, 32'd0);
        check("rst_res_out", res_out, 32'd0);
        check("rst_valids", {28'd0, down_valid, right_valid, res_out_valid, ovf}, 32'd0);
        step();
        rst = 1'b1;

        // Four fires of 1.0*2.0, single pulse two cycles after the last fire
        mac_group(1'b0, 1, 2, 1'b1);
        @(negedge clk);
        check("lat_t0_valid", {31'd0, res_out_valid}, 32'd0);
        step();
        @(negedge clk);
        check("lat_t1_valid", {31'd0, res_out_valid}, 32'd0);
        step();
        @(negedge clk);
        check("lat_t2_valid", {31'd0, res_out_valid}, 32'd1);
        check("lat_t2_value", res_out, 32'h41000000);
        step();
        @(negedge clk);
        check("lat_t3_valid", {31'd0, res_out_valid}, 32'd0);

        // Pass-through with clear held: no fire may result
        up = 32'h12345678;
        left = 32'h9abcdef0;
        up_valid = 1'b1;
        left_valid = 1'b1;
        clear = 1'b1;
        step();
        @(negedge clk);
        check("pass_down", down, 32'h12345678);
        check("pass_right", right, 32'h9abcdef0);
        check("pass_valids", {30'd0, down_valid, right_valid}, 32'd3);
        idle(1);
        @(negedge clk);
        check("pass_valids_off", {30'd0, down_valid, right_valid}, 32'd0);
        idle(6);

        repeat (3) mac_group(1'b1, 0, 0, 1'b1);
        idle(6);

        // Drain contention: neighbour result goes first, local one next cycle
        mac_group(1'b0, 2, 3, 1'b0);
        exp_q.push_back(32'h40400000);
        exp_q.push_back(int_to_fp(24));
        step();
        res_in = 32'h40400000;
        res_in_valid = 1'b1;
        step();
        idle(5);

        // Overflow: chain busy across two local completions, first result lost
        res_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            res_in = int_to_fp(100 + i);
            exp_q.push_back(res_in);
            up = int_to_fp(1);
            left = int_to_fp(i < 4 ? 1 : 3);
            up_valid = (i < 8);
            left_valid = (i < 8);
            step();
        end
        up_valid = 1'b0;
        left_valid = 1'b0;
        res_in_valid = 1'b0;
        exp_q.push_back(int_to_fp(12));
        step();
        @(negedge clk);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        idle(3);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        check("ovf_cleared", {31'd0, ovf}, 32'd0);

        // clear after two fires discards the partial sum and the in-flight product
        fire(1, 1);
        fire(1, 1);
        up_valid = 1'b0;
        left_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        mac_group(1'b0, 1, 1, 1'b1);
        idle(6);

        // Reset after three fires
        fire(1, 2);
        fire(1, 2);
        fire(1, 2);
        up_valid = 1'b0;
        left_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_down", down, 32'd0);
        check("midrst_res_out", res_out, 32'd0);
        check("midrst_valids", {29'd0, down_valid, res_out_valid, ovf}, 32'd0);
        step();
        rst = 1'b1;
        mac_group(1'b0, 1, 2, 1'b1);
        idle(6);
        check("post_rst_ovf", {31'd0, ovf}, 32'd0);

        // Reset with a completed result still pending: it must never appear
        mac_group(1'b0, 5, 5, 1'b0);
        step();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        idle(6);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
